// File: rtl/ping_pong_bank_ctrl.sv
// Fill/drain sequencer for one two-bank ping-pong buffer: steers producer beats into the
// filling bank, drains the full bank slice by slice, and swaps roles on fill/drain completion.
module ping_pong_bank_ctrl #(
    parameter int ADDR_WIDTH    = 8,
    parameter int FILL_DEPTH    = 12,
    parameter int DRAIN_DEPTH   = 12,
    parameter int TOTAL_MODULES = 4,
    localparam int SLICE_W      = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  rd_req,
    output logic                  out_valid,
    output logic [SLICE_W-1:0]    slicing_idx,
    output logic                  rd_bank_sel,
    output logic                  bank0_ena,
    output logic                  bank1_ena,
    output logic                  bank0_wea,
    output logic                  bank1_wea,
    output logic [ADDR_WIDTH-1:0] bank0_addra,
    output logic [ADDR_WIDTH-1:0] bank1_addra,
    output logic [1:0]            full,
    output logic                  drain_done
);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_DRAIN = 2'd1,
        R_FLUSH = 2'd2
    } rd_state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] FILL_LAST   = ADDR_WIDTH'(FILL_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST  = ADDR_WIDTH'(DRAIN_DEPTH - 1);
    localparam logic [SLICE_W-1:0]    SLICE_ONE   = SLICE_W'(1);
    localparam logic [SLICE_W-1:0]    SLICE_ZERO  = SLICE_W'(0);
    localparam logic [SLICE_W-1:0]    SLICE_LAST  = SLICE_W'(TOTAL_MODULES - 1);

    rd_state_t              state_r;
    rd_state_t              state_nxt_s;
    logic                   wr_bank_r;
    logic                   rd_bank_r;
    logic [1:0]             full_r;
    logic [1:0]             full_nxt_s;
    logic [ADDR_WIDTH-1:0]  wr_addr_r;
    logic [ADDR_WIDTH-1:0]  rd_addr_r;
    logic [SLICE_W-1:0]     slice_cnt_r;
    logic                   out_valid_r;
    logic [SLICE_W-1:0]     slicing_idx_r;
    logic                   rd_bank_sel_r;

    logic                   in_ready_s;
    logic                   wr_fire_s;
    logic                   wr_last_s;
    logic                   rd_fire_s;
    logic                   rd_addr_last_s;
    logic                   rd_last_s;
    logic                   flush_s;
    logic                   wr0_s;
    logic                   wr1_s;
    logic                   rd0_s;
    logic                   rd1_s;

    // Write-side handshake decode from registered state only
    always_comb begin
        in_ready_s     = ~full_r[wr_bank_r];
        wr_fire_s      = in_valid & in_ready_s;
        wr_last_s      = (wr_addr_r == FILL_LAST);
        rd_addr_last_s = (rd_addr_r == DRAIN_LAST);
        rd_last_s      = rd_addr_last_s & (slice_cnt_r == SLICE_LAST);
    end

    // Read FSM next-state and issue/flush strobes
    always_comb begin
        state_nxt_s = state_r;
        rd_fire_s   = 1'b0;
        flush_s     = 1'b0;
        case (state_r)
            R_IDLE: begin
                if (full_r[rd_bank_r]) begin
                    state_nxt_s = R_DRAIN;
                end else begin
                    state_nxt_s = R_IDLE;
                end
            end
            R_DRAIN: begin
                if (rd_req) begin
                    rd_fire_s = 1'b1;
                    if (rd_last_s) begin
                        state_nxt_s = R_FLUSH;
                    end else begin
                        state_nxt_s = R_DRAIN;
                    end
                end else begin
                    state_nxt_s = R_DRAIN;
                end
            end
            R_FLUSH: begin
                flush_s     = 1'b1;
                state_nxt_s = R_IDLE;
            end
            default: begin
                state_nxt_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= R_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fill completion sets the write bank's flag while a flush clears the read bank's; both may land together
    always_comb begin
        full_nxt_s = (full_r | ((wr_fire_s & wr_last_s) ? {wr_bank_r, ~wr_bank_r} : 2'b00))
                   & ~(flush_s ? {rd_bank_r, ~rd_bank_r} : 2'b00);
    end

    // Full flags
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 2'b00;
        end else begin
            full_r <= full_nxt_s;
        end
    end

    // Write address and bank pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_r <= ADDR_ZERO;
            wr_bank_r <= 1'b0;
        end else if (wr_fire_s) begin
            if (wr_last_s) begin
                wr_addr_r <= ADDR_ZERO;
                wr_bank_r <= ~wr_bank_r;
            end else begin
                wr_addr_r <= wr_addr_r + ADDR_ONE;
            end
        end
    end

    // Drain counters: slice is the outer loop, address the inner
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_r   <= ADDR_ZERO;
            slice_cnt_r <= SLICE_ZERO;
            rd_bank_r   <= 1'b0;
        end else if (flush_s) begin
            rd_addr_r   <= ADDR_ZERO;
            slice_cnt_r <= SLICE_ZERO;
            rd_bank_r   <= ~rd_bank_r;
        end else if (rd_fire_s) begin
            if (rd_addr_last_s) begin
                rd_addr_r   <= ADDR_ZERO;
                slice_cnt_r <= rd_last_s ? SLICE_ZERO : (slice_cnt_r + SLICE_ONE);
            end else begin
                rd_addr_r   <= rd_addr_r + ADDR_ONE;
            end
        end
    end

    // One-cycle delay matching the BRAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            slicing_idx_r <= SLICE_ZERO;
            rd_bank_sel_r <= 1'b0;
        end else begin
            out_valid_r   <= rd_fire_s;
            slicing_idx_r <= slice_cnt_r;
            rd_bank_sel_r <= rd_bank_r;
        end
    end

    // Port-A steering; a bank is never written and read in the same cycle
    always_comb begin
        wr0_s       = wr_fire_s & ~wr_bank_r;
        wr1_s       = wr_fire_s &  wr_bank_r;
        rd0_s       = rd_fire_s & ~rd_bank_r;
        rd1_s       = rd_fire_s &  rd_bank_r;
        bank0_ena   = wr0_s | rd0_s;
        bank1_ena   = wr1_s | rd1_s;
        bank0_wea   = wr0_s;
        bank1_wea   = wr1_s;
        bank0_addra = wr0_s ? wr_addr_r : (rd0_s ? rd_addr_r : ADDR_ZERO);
        bank1_addra = wr1_s ? wr_addr_r : (rd1_s ? rd_addr_r : ADDR_ZERO);
    end

    // Output port drive
    always_comb begin
        in_ready    = in_ready_s;
        full        = full_r;
        drain_done  = flush_s;
        out_valid   = out_valid_r;
        slicing_idx = slicing_idx_r;
        rd_bank_sel = rd_bank_sel_r;
    end

endmodule

// File: tb/tb_ping_pong_bank_ctrl.sv
// Self-checking bench for ping_pong_bank_ctrl: per-scenario tasks compared against a
// transaction-level model (per-bank fill counts, linear drain index split into slice/addr).
module tb_ping_pong_bank_ctrl;

    localparam int AW = 8;
    localparam int FD = 12;
    localparam int DD = 12;
    localparam int TM = 4;
    localparam int SW = 2;
    localparam int VW = 1 + 2 + 2 * (2 + AW) + 1 + SW + 1 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          rd_req;
    logic          out_valid;
    logic [SW-1:0] slicing_idx;
    logic          rd_bank_sel;
    logic          bank0_ena, bank1_ena, bank0_wea, bank1_wea;
    logic [AW-1:0] bank0_addra, bank1_addra;
    logic [1:0]    full;
    logic          drain_done;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // reference model state
    int       fill_cnt [2];
    bit       wr_b, rd_b;
    int       drain_n;
    bit       draining, flushing;
    bit       pend_ov, pend_bank;
    int       pend_slice;
    bit       m_acc, m_issue, cur_r;
    bit [1:0] m_full;

    logic [VW-1:0] exp_v;
    logic [VW-1:0] obs_v;

    assign obs_v = {in_ready, full, bank0_ena, bank0_wea, bank0_addra,
                    bank1_ena, bank1_wea, bank1_addra, out_valid, slicing_idx,
                    rd_bank_sel, drain_done};

    ping_pong_bank_ctrl #(.ADDR_WIDTH(AW), .FILL_DEPTH(FD), .DRAIN_DEPTH(DD), .TOTAL_MODULES(TM)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .rd_req(rd_req),
        .out_valid(out_valid), .slicing_idx(slicing_idx), .rd_bank_sel(rd_bank_sel),
        .bank0_ena(bank0_ena), .bank1_ena(bank1_ena), .bank0_wea(bank0_wea), .bank1_wea(bank1_wea),
        .bank0_addra(bank0_addra), .bank1_addra(bank1_addra), .full(full), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        fill_cnt[0] = 0; fill_cnt[1] = 0;
        wr_b = 1'b0; rd_b = 1'b0; drain_n = 0;
        draining = 1'b0; flushing = 1'b0;
        pend_ov = 1'b0; pend_bank = 1'b0; pend_slice = 0;
    endtask

    // Expected outputs of the current cycle from model state and this cycle's inputs
    task automatic model_predict(input logic iv, input logic rr);
        logic          ir, e0, w0, e1, w1;
        logic [AW-1:0] a0, a1;
        m_full[0] = (fill_cnt[0] == FD);
        m_full[1] = (fill_cnt[1] == FD);
        ir      = !m_full[wr_b];
        m_acc   = iv && ir;
        m_issue = draining && rr;
        e0 = 1'b0; w0 = 1'b0; a0 = '0; e1 = 1'b0; w1 = 1'b0; a1 = '0;
        if (m_acc) begin
            if (wr_b == 1'b0) begin e0 = 1'b1; w0 = 1'b1; a0 = AW'(fill_cnt[0]); end
            else              begin e1 = 1'b1; w1 = 1'b1; a1 = AW'(fill_cnt[1]); end
        end
        if (m_issue) begin
            if (rd_b == 1'b0) begin e0 = 1'b1; a0 = AW'(drain_n % DD); end
            else              begin e1 = 1'b1; a1 = AW'(drain_n % DD); end
        end
        exp_v = {ir, m_full, e0, w0, a0, e1, w1, a1, pend_ov, SW'(pend_slice), pend_bank, flushing};
    endtask

    task automatic model_advance(input bit r);
        if (r) begin
            model_reset();
        end else begin
            pend_ov    = m_issue;
            pend_slice = drain_n / DD;
            pend_bank  = rd_b;
            if (m_acc) begin
                fill_cnt[wr_b] = fill_cnt[wr_b] + 1;
                if (fill_cnt[wr_b] == FD) wr_b = !wr_b;
            end
            if (flushing) begin
                fill_cnt[rd_b] = 0;
                rd_b     = !rd_b;
                flushing = 1'b0;
            end else if (draining) begin
                if (m_issue) begin
                    drain_n = drain_n + 1;
                    if (drain_n == TM * DD) begin
                        drain_n = 0; draining = 1'b0; flushing = 1'b1;
                    end
                end
            end else if (m_full[rd_b]) begin
                draining = 1'b1;
            end
        end
    endtask

    task automatic cyc_begin(input logic r, input logic iv, input logic rr);
        rst = r; in_valid = iv; rd_req = rr;
        @(negedge clk);
        model_predict(iv, rr);
        cur_r = r;
    endtask

    task automatic cyc_end();
        model_advance(cur_r);
        cycle++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cyc_begin(1'b1, 1'b0, 1'b0);
        cyc_end();
    endtask

    task automatic test_reset();
        cyc_begin(1'b1, 1'b0, 1'b0);
        total++;
        if ({in_ready, full, out_valid, bank0_ena, bank1_ena, drain_done} !== 7'b1000000) begin
            bad++; $display("FAIL reset_vals got=%b want=1000000", {in_ready, full, out_valid, bank0_ena, bank1_ena, drain_done});
        end
        cyc_end();
        for (int i = 0; i < 8; i++) begin
            cyc_begin(1'b0, (i >= 3) ? 1'b1 : 1'b0, 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cycle, obs_v, exp_v); end
            cyc_end();
        end
        cyc_begin(1'b1, 1'b1, 1'b0);
        cyc_end();
        cyc_begin(1'b0, 1'b0, 1'b0);
        total++;
        if ({in_ready, full, out_valid, bank0_ena, bank1_ena, drain_done} !== 7'b1000000) begin
            bad++; $display("FAIL reset_midstream got=%b want=1000000", {in_ready, full, out_valid, bank0_ena, bank1_ena, drain_done});
        end
        cyc_end();
    endtask

    task automatic test_single_drain();
        int slices[$];
        int done_cnt = 0;
        int after = -1;
        do_reset();
        for (int k = 0; k < FD; k++) begin
            cyc_begin(1'b0, 1'b1, 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL single_fill cyc=%0d got=%h want=%h", cycle, obs_v, exp_v); end
            total++;
            if ({bank0_ena, bank0_wea, bank0_addra} !== {2'b11, AW'(k)}) begin
                bad++; $display("FAIL single_fill_addr got=%0d want=%0d", bank0_addra, k);
            end
            cyc_end();
        end
        cyc_begin(1'b0, 1'b0, 1'b1);
        total++;
        if (full !== 2'b01) begin bad++; $display("FAIL single_full got=%b want=01", full); end
        cyc_end();
        for (int c = 0; c < 120 && after != 0; c++) begin
            cyc_begin(1'b0, 1'b0, (after < 0) ? 1'b1 : 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL single_drain cyc=%0d got=%h want=%h", cycle, obs_v, exp_v); end
            if (out_valid) begin
                slices.push_back(int'(slicing_idx));
                total++;
                if (rd_bank_sel !== 1'b0) begin bad++; $display("FAIL single_bank_sel got=%b want=0", rd_bank_sel); end
            end
            if (drain_done) begin
                done_cnt++;
                if (after < 0) after = 3;
            end
            if (after > 0) after--;
            cyc_end();
        end
        total++;
        if (after != 0) begin bad++; $display("FAIL single_timeout got=no_drain_done want=drain_done"); end
        total++;
        if (slices.size() != TM * DD) begin bad++; $display("FAIL single_beats got=%0d want=%0d", slices.size(), TM * DD); end
        for (int i = 0; i < slices.size(); i++) begin
            total++;
            if (slices[i] != i / DD) begin bad++; $display("FAIL single_slice idx=%0d got=%0d want=%0d", i, slices[i], i / DD); end
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL single_done_cnt got=%0d want=1", done_cnt); end
        cyc_begin(1'b0, 1'b0, 1'b0);
        total++;
        if ({full, rd_bank_sel} !== 3'b001) begin bad++; $display("FAIL single_after got=%b want=001", {full, rd_bank_sel}); end
        cyc_end();
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int done_cyc = -1;
        int ready_cyc = -1;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            cyc_begin(1'b0, 1'b1, 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL b2b_fill cyc=%0d got=%h want=%h", cycle, obs_v, exp_v); end
            if (in_ready) acc++;
            if (c >= 2 * FD) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_low beat=%0d got=%b want=0", c + 1, in_ready); end
            end
            cyc_end();
        end
        total++;
        if (acc != 2 * FD) begin bad++; $display("FAIL b2b_accepted got=%0d want=%0d", acc, 2 * FD); end
        total++;
        if (full !== 2'b11) begin bad++; $display("FAIL b2b_full got=%b want=11", full); end
        for (int c = 0; c < 120 && ready_cyc < 0; c++) begin
            cyc_begin(1'b0, 1'b1, 1'b1);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL b2b_drain cyc=%0d got=%h want=%h", cycle, obs_v, exp_v); end
            if (drain_done && done_cyc < 0) done_cyc = c;
            if (in_ready) ready_cyc = c;
            cyc_end();
        end
        total++;
        if (done_cyc < 0 || ready_cyc != done_cyc + 1) begin
            bad++; $display("FAIL b2b_ready_return got=%0d want=%0d", ready_cyc, done_cyc + 1);
        end
    endtask

    task automatic test_throttle();
        int ov_cnt = 0;
        bit prev_issue = 1'b0;
        bit done = 1'b0;
        do_reset();
        for (int k = 0; k < FD; k++) begin
            cyc_begin(1'b0, 1'b1, 1'b0);
            cyc_end();
        end
        for (int c = 0; c < 250 && !done; c++) begin
            cyc_begin(1'b0, 1'b0, (c % 2 == 0) ? 1'b1 : 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL thr_cycle cyc=%0d got=%h want=%h", cycle, obs_v, exp_v); end
            if (!rd_req) begin
                total++;
                if (bank0_ena !== 1'b0) begin bad++; $display("FAIL thr_idle_issue got=%b want=0", bank0_ena); end
            end
            if (out_valid) begin
                ov_cnt++;
                total++;
                if (!prev_issue) begin bad++; $display("FAIL thr_spurious_valid got=1 want=0"); end
            end
            prev_issue = bank0_ena & ~bank0_wea;
            if (drain_done) done = 1'b1;
            cyc_end();
        end
        total++;
        if (ov_cnt != TM * DD) begin bad++; $display("FAIL thr_valid_cnt got=%0d want=%0d", ov_cnt, TM * DD); end
    endtask

    task automatic test_coincide();
        do_reset();
        for (int c = 0; c < FD + 38 + FD; c++) begin
            cyc_begin(1'b0, (c < FD || c >= FD + 38) ? 1'b1 : 1'b0, 1'b1);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL coin_cycle cyc=%0d got=%h want=%h", cycle, obs_v, exp_v); end
            if (c == FD + 38 + FD - 1) begin
                total++;
                if ({drain_done, bank1_ena, bank1_wea, bank1_addra} !== {3'b111, AW'(FD - 1)}) begin
                    bad++; $display("FAIL coin_same_cycle got=%b want=111 addr=%0d", {drain_done, bank1_ena, bank1_wea}, bank1_addra);
                end
            end
            cyc_end();
        end
        cyc_begin(1'b0, 1'b1, 1'b1);
        total++;
        if ({full, in_ready, bank0_ena, bank0_wea, bank0_addra} !== {2'b10, 3'b111, AW'(0)}) begin
            bad++; $display("FAIL coin_after got=%b_%b_%b%b_%0d want=10_1_11_0", full, in_ready, bank0_ena, bank0_wea, bank0_addra);
        end
        cyc_end();
    endtask

    task automatic test_reset_mid_drain();
        int issued = 0;
        do_reset();
        for (int k = 0; k < FD; k++) begin
            cyc_begin(1'b0, 1'b1, 1'b0);
            cyc_end();
        end
        for (int c = 0; c < 60 && issued < 20; c++) begin
            cyc_begin(1'b0, 1'b0, 1'b1);
            if (bank0_ena && !bank0_wea) issued++;
            cyc_end();
        end
        total++;
        if (issued != 20) begin bad++; $display("FAIL rstd_issue_cnt got=%0d want=20", issued); end
        cyc_begin(1'b1, 1'b0, 1'b1);
        cyc_end();
        for (int c = 0; c < 4; c++) begin
            cyc_begin(1'b0, 1'b0, 1'b1);
            total++;
            if ({full, out_valid, bank0_ena, bank1_ena, drain_done} !== 6'b000000) begin
                bad++; $display("FAIL rstd_idle got=%b want=000000", {full, out_valid, bank0_ena, bank1_ena, drain_done});
            end
            cyc_end();
        end
        for (int k = 0; k < FD; k++) begin
            cyc_begin(1'b0, 1'b1, 1'b0);
            total++;
            if ({bank0_ena, bank0_wea, bank0_addra} !== {2'b11, AW'(k)}) begin
                bad++; $display("FAIL rstd_refill got=%0d want=%0d", bank0_addra, k);
            end
            cyc_end();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            cyc_begin(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
            total++;
            if (obs_v !== exp_v) begin bad++; $display("FAIL rand_cycle cyc=%0d got=%h want=%h", cycle, obs_v, exp_v); end
            cyc_end();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; rd_req = 1'b0; cur_r = 1'b1;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_single_drain();
        test_back_to_back();
        test_throttle();
        test_coincide();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
